// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: IRQ codes, FSM encoding,
// pending-bit record and the saturating increment used by overrun counters.
package int_pkg;

   typedef logic [1:0] irq_code_t;
   typedef logic [1:0] state_t;

   typedef struct packed {
      logic kbd;
      logic tmr;
   } pend_t;

   localparam irq_code_t IRQ_TIMER = 2'b00;
   localparam irq_code_t IRQ_KBD   = 2'b01;
   localparam irq_code_t IRQ_NONE  = 2'b11;

   localparam state_t ST_IDLE    = 2'b00;
   localparam state_t ST_PRESENT = 2'b01;
   localparam state_t ST_SERVICE = 2'b10;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/int_timer.sv
// System-timer prescaler: counts 0..TIMER_DIV-1 while ENABLE is high and
// pulses TICK in the terminal-count cycle.
module int_timer #(
   parameter logic [19:0] TIMER_DIV = 20'd833333
) (
   input  logic CLK,
   input  logic RESET,
   input  logic ENABLE,
   output logic TICK
);

   localparam logic [19:0] LAST = TIMER_DIV - 20'd1;

   logic [19:0] cnt_q;
   logic [19:0] cnt_d;

   always_comb begin
      TICK  = ENABLE && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (ENABLE) begin
         cnt_d = TICK ? '0 : cnt_q + 20'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Two-source (timer, keyboard) interrupt controller with IDLE/PRESENT/SERVICE
// handshake. Optional merged-event counters enabled by INT_OVERRUN_CNT_EN.
module interrupt_controller
   import int_pkg::*;
#(
   parameter logic [19:0] TIMER_DIV = 20'd833333
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       KBD_STROBE,
   input  logic       INT_IACK,
   input  logic       INT_IEND,
   output logic [1:0] INT_IRQ,
   output logic       INT_BUSY
`ifdef INT_OVERRUN_CNT_EN
   ,
   output logic [7:0] OVERRUN
`endif
);

   logic      tick;
   logic      kbd_evt;
   state_t    state_q, state_d;
   irq_code_t sel_q, sel_d;
   irq_code_t irq_q, irq_d;
   pend_t     pend_q, pend_d;
   pend_t     clr;

   int_timer #(
      .TIMER_DIV(TIMER_DIV)
   ) u_timer (
      .CLK   (CLK),
      .RESET (RESET),
      .ENABLE(ENABLE),
      .TICK  (tick)
   );

   assign kbd_evt = ENABLE & KBD_STROBE;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      irq_d   = irq_q;
      clr     = '0;
      case (state_q)
         ST_IDLE: begin
            if (pend_q.tmr || pend_q.kbd) begin
               state_d = ST_PRESENT;
               sel_d   = pend_q.tmr ? IRQ_TIMER : IRQ_KBD;
               irq_d   = sel_d;
            end
         end
         ST_PRESENT: begin
            if (INT_IACK) begin
               state_d = ST_SERVICE;
               irq_d   = IRQ_NONE;
               clr.tmr = (sel_q == IRQ_TIMER);
               clr.kbd = (sel_q == IRQ_KBD);
            end
         end
         ST_SERVICE: begin
            irq_d = IRQ_NONE;
            if (INT_IEND) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = IRQ_NONE;
         end
      endcase
      // a new event in the acknowledge cycle survives the clear
      pend_d.tmr = (pend_q.tmr & ~clr.tmr) | tick;
      pend_d.kbd = (pend_q.kbd & ~clr.kbd) | kbd_evt;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         sel_q   <= IRQ_NONE;
         irq_q   <= IRQ_NONE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         irq_q   <= irq_d;
         pend_q  <= pend_d;
      end
   end

   assign INT_IRQ  = irq_q;
   assign INT_BUSY = (state_q == ST_PRESENT) || (state_q == ST_SERVICE);

`ifdef INT_OVERRUN_CNT_EN
   logic [3:0] ovr_tmr_q, ovr_tmr_d;
   logic [3:0] ovr_kbd_q, ovr_kbd_d;

   // merged = event for a request still pending and not being consumed now
   always_comb begin
      ovr_tmr_d = ovr_tmr_q;
      ovr_kbd_d = ovr_kbd_q;
      if (tick && pend_q.tmr && !clr.tmr) begin
         ovr_tmr_d = sat_inc4(ovr_tmr_q);
      end
      if (kbd_evt && pend_q.kbd && !clr.kbd) begin
         ovr_kbd_d = sat_inc4(ovr_kbd_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ovr_tmr_q <= '0;
         ovr_kbd_q <= '0;
      end else begin
         ovr_tmr_q <= ovr_tmr_d;
         ovr_kbd_q <= ovr_kbd_d;
      end
   end

   assign OVERRUN = {ovr_kbd_q, ovr_tmr_q};
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (TIMER_DIV=4 main instance, TIMER_DIV=1 edge instance).
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       en1 = 1'b0;
   logic       kbd = 1'b0;
   logic       iack = 1'b0;
   logic       iend = 1'b0;
   logic [1:0] irq;
   logic       busy;
   logic [1:0] irq1;
   logic       busy1;
   int         pass_cnt = 0;
   int         total_cnt = 0;
`ifdef INT_OVERRUN_CNT_EN
   logic [7:0] ovr;
   logic [7:0] ovr1;
`endif

   always #5 clk = ~clk;

   interrupt_controller #(.TIMER_DIV(20'd4)) u_dut (
      .CLK       (clk),
      .RESET     (rst),
      .ENABLE    (en),
      .KBD_STROBE(kbd),
      .INT_IACK  (iack),
      .INT_IEND  (iend),
      .INT_IRQ   (irq),
      .INT_BUSY  (busy)
`ifdef INT_OVERRUN_CNT_EN
      ,
      .OVERRUN   (ovr)
`endif
   );

   interrupt_controller #(.TIMER_DIV(20'd1)) u_dut1 (
      .CLK       (clk),
      .RESET     (rst),
      .ENABLE    (en1),
      .KBD_STROBE(1'b0),
      .INT_IACK  (1'b0),
      .INT_IEND  (1'b0),
      .INT_IRQ   (irq1),
      .INT_BUSY  (busy1)
`ifdef INT_OVERRUN_CNT_EN
      ,
      .OVERRUN   (ovr1)
`endif
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // returns at the negedge of cycle 0: registers reset, timer count 0
   task automatic do_reset();
      rst = 1'b1; en = 1'b0; en1 = 1'b0; kbd = 1'b0; iack = 1'b0; iend = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (irq !== 2'b11) $display("FAIL reset_irq got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
`ifdef INT_OVERRUN_CNT_EN
      total_cnt++; if (ovr !== 8'h00) $display("FAIL reset_ovr got=%h exp=00", ovr); else pass_cnt++;
`endif
   endtask

   task automatic test_timer();
      do_reset();
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         total_cnt++; if (irq !== 2'b11) $display("FAIL tmr_pre_c%0d got=%b exp=11", k, irq); else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (irq !== 2'b00) $display("FAIL tmr_c5_irq got=%b exp=00", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL tmr_c5_busy got=%b exp=1", busy); else pass_cnt++;
      en = 1'b0;
      cyc(2);
      total_cnt++; if (irq !== 2'b00) $display("FAIL tmr_hold_disabled got=%b exp=00", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL tmr_iack_irq got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL tmr_service_busy got=%b exp=1", busy); else pass_cnt++;
      iend = 1'b1; cyc(1); iend = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL tmr_iend_busy got=%b exp=0", busy); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq !== 2'b11) $display("FAIL tmr_idle_irq got=%b exp=11", irq); else pass_cnt++;
   endtask

   task automatic test_kbd();
      do_reset();
      kbd = 1'b1; cyc(1); kbd = 1'b0;
      cyc(1);
      total_cnt++; if (irq !== 2'b11) $display("FAIL kbd_disabled_ignored got=%b exp=11", irq); else pass_cnt++;
      en = 1'b1; kbd = 1'b1; cyc(1); en = 1'b0; kbd = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL kbd_n1 got=%b exp=11", irq); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq !== 2'b01) $display("FAIL kbd_n2 got=%b exp=01", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL kbd_n2_busy got=%b exp=1", busy); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL kbd_iack got=%b exp=11", irq); else pass_cnt++;
      iend = 1'b1; cyc(1); iend = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL kbd_iend_busy got=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      en = 1'b1;
      cyc(3);
      kbd = 1'b1; cyc(1); kbd = 1'b0; en = 1'b0;
      cyc(1);
      total_cnt++; if (irq !== 2'b00) $display("FAIL simul_timer_first got=%b exp=00", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      iend = 1'b1; cyc(1); iend = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL simul_idle_busy got=%b exp=0", busy); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq !== 2'b01) $display("FAIL simul_kbd_second got=%b exp=01", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      iend = 1'b1; cyc(1); iend = 1'b0;
   endtask

   task automatic test_merge();
      do_reset();
      en = 1'b1; cyc(4); en = 1'b0;
      cyc(1);
      total_cnt++; if (irq !== 2'b00) $display("FAIL merge_timer got=%b exp=00", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      en = 1'b1; kbd = 1'b1; cyc(3); kbd = 1'b0; en = 1'b0;
      total_cnt++; if (busy !== 1'b1) $display("FAIL merge_still_service got=%b exp=1", busy); else pass_cnt++;
      iend = 1'b1; cyc(1); iend = 1'b0;
      cyc(1);
      total_cnt++; if (irq !== 2'b01) $display("FAIL merge_kbd_req got=%b exp=01", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      iend = 1'b1; cyc(1); iend = 1'b0;
      cyc(1);
      total_cnt++; if (irq !== 2'b11) $display("FAIL merge_single_req got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL merge_single_busy got=%b exp=0", busy); else pass_cnt++;
`ifdef INT_OVERRUN_CNT_EN
      total_cnt++; if (ovr !== 8'h20) $display("FAIL merge_overrun got=%h exp=20", ovr); else pass_cnt++;
      rst = 1'b1; cyc(1); rst = 1'b0;
      total_cnt++; if (ovr !== 8'h00) $display("FAIL overrun_reset got=%h exp=00", ovr); else pass_cnt++;
`endif
   endtask

   task automatic test_illegal();
      do_reset();
      iack = 1'b1; cyc(1); iack = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL iack_idle_irq got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL iack_idle_busy got=%b exp=0", busy); else pass_cnt++;
      en = 1'b1; kbd = 1'b1; cyc(1); en = 1'b0; kbd = 1'b0;
      cyc(1);
      iend = 1'b1; cyc(1); iend = 1'b0;
      total_cnt++; if (irq !== 2'b01) $display("FAIL iend_present_irq got=%b exp=01", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL iend_present_busy got=%b exp=1", busy); else pass_cnt++;
      iack = 1'b1; iend = 1'b1; en = 1'b1; kbd = 1'b1; cyc(1); en = 1'b0; kbd = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL both_in_present_irq got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL both_in_present_busy got=%b exp=1", busy); else pass_cnt++;
      cyc(1); iack = 1'b0; iend = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL both_in_service_busy got=%b exp=0", busy); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq !== 2'b01) $display("FAIL set_wins_irq got=%b exp=01", irq); else pass_cnt++;
      iack = 1'b1; cyc(1); iack = 1'b0;
      iend = 1'b1; cyc(1); iend = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 1'b1; kbd = 1'b1; cyc(1); kbd = 1'b0;
      cyc(1);
      iack = 1'b1; cyc(1); iack = 1'b0;
      cyc(1);
      rst = 1'b1; cyc(1); rst = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL rstmid_irq got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
      iend = 1'b1; cyc(1); iend = 1'b0;
      iack = 1'b1; cyc(1); iack = 1'b0;
      total_cnt++; if (irq !== 2'b11) $display("FAIL rstmid_pend_cleared got=%b exp=11", irq); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_ignored_busy got=%b exp=0", busy); else pass_cnt++;
      cyc(2);
      total_cnt++; if (irq !== 2'b11) $display("FAIL rstmid_timer_c9 got=%b exp=11", irq); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq !== 2'b00) $display("FAIL rstmid_timer_c10 got=%b exp=00", irq); else pass_cnt++;
      en = 1'b0;
   endtask

   task automatic test_div1();
      do_reset();
      en1 = 1'b1;
      cyc(1);
      total_cnt++; if (irq1 !== 2'b11) $display("FAIL div1_c1 got=%b exp=11", irq1); else pass_cnt++;
      cyc(1);
      total_cnt++; if (irq1 !== 2'b00) $display("FAIL div1_c2 got=%b exp=00", irq1); else pass_cnt++;
      total_cnt++; if (busy1 !== 1'b1) $display("FAIL div1_busy got=%b exp=1", busy1); else pass_cnt++;
      en1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_timer();
      test_kbd();
      test_simultaneous();
      test_merge();
      test_illegal();
      test_reset_mid();
      test_div1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter TIMER_DIV, default 20'd833333, is the system-timer period in CLK cycles (60 Hz at 50 MHz); legal range 1..2^20-1.
REQ-002 CLK  input  1  single system clock; all logic on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ENABLE  input  1  low: timer count held, new events not latched.
REQ-005 KBD_STROBE  input  1  one-cycle pulse per decoded keystroke from keyboard controller.
REQ-006 INT_IACK  input  1  processor acknowledge of the presented request.
REQ-007 INT_IEND  input  1  processor end-of-interrupt.
REQ-008 INT_IRQ  output  2  registered request code: 2'b00 timer, 2'b01 keyboard, 2'b11 none; 2'b10 never driven.
REQ-009 INT_BUSY  output  1  high while state is PRESENT or SERVICE.

Function
REQ-010 The timer counter SHALL count 0..TIMER_DIV-1 while ENABLE=1, raise an internal tick in the cycle count==TIMER_DIV-1, then wrap to 0; TIMER_DIV=1 ticks every enabled cycle.
REQ-011 A tick SHALL set pend_tmr and a KBD_STROBE (ENABLE=1) SHALL set pend_kbd on the next edge.
REQ-012 States: IDLE, PRESENT, SERVICE; RESET forces IDLE.
REQ-013 IDLE: if any pending bit is set, SHALL go to PRESENT latching source sel (timer has priority over keyboard); otherwise stay.
REQ-014 PRESENT: INT_IRQ SHALL show sel code; on INT_IACK=1, SHALL go to SERVICE, clear the pending bit of sel, and drive INT_IRQ=2'b11 from the same edge.
REQ-015 SERVICE: INT_IRQ SHALL be 2'b11; on INT_IEND=1, SHALL go to IDLE.
REQ-016 Latency: KBD_STROBE in cycle n with state IDLE and nothing pending SHALL give INT_IRQ=2'b01 in cycle n+2.
REQ-017 INT_IACK outside PRESENT and INT_IEND outside SERVICE SHALL be ignored; simultaneous IACK and IEND SHALL honour only the one legal for the current state.
REQ-018 An event setting a pending bit in the same cycle IACK clears it SHALL leave it set (set wins).
REQ-019 An event for a source whose pending bit is already set SHALL be merged (no queueing).
REQ-020 A higher-priority event arriving while in PRESENT SHALL NOT change the presented code.
REQ-021 ENABLE=0 SHALL NOT abort an in-progress PRESENT/SERVICE sequence.

Reset
REQ-022 On RESET: state IDLE, INT_IRQ=2'b11, INT_BUSY=0, pend_tmr=pend_kbd=0, timer count 0, overrun counters 0.
REQ-023 RESET mid-sequence SHALL discard the in-flight request; a following IACK/IEND SHALL be ignored.

Configuration
REQ-024 Macro INT_OVERRUN_CNT_EN defined: output OVERRUN  output  8  {kbd[3:0], tmr[3:0]} saturating counts of merged events (REQ-019), cleared only by RESET.
REQ-025 Macro INT_OVERRUN_CNT_EN undefined: OVERRUN port and counters SHALL not exist; function otherwise identical.

Structure
REQ-026 Shared package int_pkg SHALL hold IRQ code constants (IRQ_TIMER, IRQ_KBD, IRQ_NONE) and the state encoding.
REQ-027 Timer prescaler SHALL be sub-module int_timer (CLK, RESET, ENABLE -> TICK, parameter TIMER_DIV).

Verification (TIMER_DIV=4 unless stated)
REQ-028 Reset release, ENABLE=1, no keys -> INT_IRQ=2'b00 two cycles after first tick (cycle 5 after reset); stays until IACK.
REQ-029 KBD_STROBE with timer blocked (ENABLE low briefly before) -> INT_IRQ=2'b01 at n+2; IACK -> 2'b11 next cycle; IEND -> IDLE, INT_BUSY=0.
REQ-030 Tick and KBD_STROBE same cycle -> timer presented first; after IEND keyboard presented 2 cycles later.
REQ-031 Three KBD_STROBEs while in SERVICE -> one keyboard request after IEND; with macro, OVERRUN[7:4]=2.
REQ-032 IACK in IDLE and IEND in PRESENT -> no state change, INT_IRQ unchanged.
REQ-033 RESET asserted in SERVICE -> next cycle INT_IRQ=2'b11, INT_BUSY=0, pending cleared, timer restarts at 0.
